// File: rtl/clock_hms_cfg_if.sv
// Button-pulse inputs, display-mode select and BCD/enable outputs of the
// configurable HH:MM:SS clock, bundled for connection to its top level.
interface clock_hms_cfg_if;
  logic       mode;
  logic       select;
  logic       adjust;
  logic       h12;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic [3:0] hour_ones;
  logic [1:0] hour_tens;
  logic       pm;
  logic       sec_on;
  logic       min_on;
  logic       hour_on;
  logic       en1hz;

  modport master (
    output mode, select, adjust, h12,
    input  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
    input  pm, sec_on, min_on, hour_on, en1hz
  );

  modport slave (
    input  mode, select, adjust, h12,
    output sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
    output pm, sec_on, min_on, hour_on, en1hz
  );
endinterface

// File: rtl/clock_hms_cfg.sv
// BCD HH:MM:SS clock with set-mode FSM, 12/24-hour hour display, AM/PM flag,
// self-derived 1 Hz tick and blinking enable for the field being set.
module clock_hms_cfg #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic           clk,
  input  logic           n_rst,
  clock_hms_cfg_if.slave bus
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BP = CLK_HZ / BLINK_HZ;
  localparam int BW = (BP > 1) ? $clog2(BP) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLK_MAX  = BW'(BP - 1);
  localparam logic [BW-1:0] BLK_HALF = BW'(BP / 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blk_q, blk_d;
  // Fields are packed BCD: {tens, ones}
  logic [6:0]    sec_q, sec_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    hour_q, hour_d;

  logic          tick_s;
  logic          blink_s;
  logic [31:0]   cnt32_s;
  logic          pm_s;
  logic [1:0]    disp_tens_s;
  logic [3:0]    disp_ones_s;

  function automatic logic [6:0] inc_bcd60(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[6:4] == 3'd5) begin
        r = 7'd0;
      end else begin
        r = {v[6:4] + 3'd1, 4'd0};
      end
    end else begin
      r = {v[6:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [5:0] inc_bcd24(input logic [5:0] v);
    logic [5:0] r;
    if (v == 6'h23) begin
      r = 6'd0;
    end else if (v[3:0] == 4'd9) begin
      r = {v[5:4] + 2'd1, 4'd0};
    end else begin
      r = {v[5:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign tick_s  = (state_q == RUN) && (cnt_q == CNT_MAX);
  assign cnt32_s = 32'(cnt_q);
  // In set mode the divider is parked, so the blink phase comes from its own counter
  assign blink_s = (state_q == RUN) ? ((cnt32_s % 32'(BP)) < 32'(BP / 2))
                                    : (blk_q < BLK_HALF);

  // Next-state: FSM transitions, divider, blink phase and time fields
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    case (state_q)
      RUN: begin
        if (bus.mode) begin
          state_d = SET_SEC;
          cnt_d   = '0;
        end else if (tick_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
        if (tick_s) begin
          sec_d = inc_bcd60(sec_q);
          if (sec_q == 7'h59) begin
            min_d = inc_bcd60(min_q);
            if (min_q == 7'h59) begin
              hour_d = inc_bcd24(hour_q);
            end else begin
              hour_d = hour_q;
            end
          end else begin
            min_d = min_q;
          end
        end else begin
          sec_d = sec_q;
        end
      end
      SET_SEC, SET_MIN, SET_HOUR: begin
        cnt_d = '0;
        if (bus.mode) begin
          state_d = RUN;
        end else if (bus.select) begin
          case (state_q)
            SET_SEC: state_d = SET_MIN;
            SET_MIN: state_d = SET_HOUR;
            default: state_d = SET_SEC;
          endcase
        end else if (bus.adjust) begin
          case (state_q)
            SET_SEC:  sec_d  = inc_bcd60(sec_q);
            SET_MIN:  min_d  = inc_bcd60(min_q);
            SET_HOUR: hour_d = inc_bcd24(hour_q);
            default:  sec_d  = sec_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (state_d != state_q) begin
      blk_d = '0;
    end else if (blk_q == BLK_MAX) begin
      blk_d = '0;
    end else begin
      blk_d = blk_q + {{(BW-1){1'b0}}, 1'b1};
    end
  end

  // 24h -> 12h hour mapping done on BCD digits directly
  always_comb begin
    pm_s        = (hour_q[5:4] == 2'd2) ||
                  ((hour_q[5:4] == 2'd1) && (hour_q[3:0] >= 4'd2));
    disp_tens_s = hour_q[5:4];
    disp_ones_s = hour_q[3:0];
    if (bus.h12) begin
      case (hour_q[5:4])
        2'd0: begin
          if (hour_q[3:0] == 4'd0) begin
            disp_tens_s = 2'd1;
            disp_ones_s = 4'd2;
          end else begin
            disp_ones_s = hour_q[3:0];
          end
        end
        2'd1: begin
          if (hour_q[3:0] >= 4'd3) begin
            disp_tens_s = 2'd0;
            disp_ones_s = hour_q[3:0] - 4'd2;
          end else begin
            disp_ones_s = hour_q[3:0];
          end
        end
        2'd2: begin
          if (hour_q[3:0] <= 4'd1) begin
            disp_tens_s = 2'd0;
            disp_ones_s = hour_q[3:0] + 4'd8;
          end else begin
            disp_tens_s = 2'd1;
            disp_ones_s = hour_q[3:0] - 4'd2;
          end
        end
        default: begin
          disp_tens_s = hour_q[5:4];
          disp_ones_s = hour_q[3:0];
        end
      endcase
    end else begin
      disp_tens_s = hour_q[5:4];
    end
  end

  // State, divider, blink phase and time registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      blk_q   <= '0;
      sec_q   <= 7'd0;
      min_q   <= 7'd0;
      hour_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  assign bus.sec_ones  = sec_q[3:0];
  assign bus.sec_tens  = sec_q[6:4];
  assign bus.min_ones  = min_q[3:0];
  assign bus.min_tens  = min_q[6:4];
  assign bus.hour_ones = disp_ones_s;
  assign bus.hour_tens = disp_tens_s;
  assign bus.pm        = pm_s;
  assign bus.sec_on    = (state_q != SET_SEC)  | blink_s;
  assign bus.min_on    = (state_q != SET_MIN)  | blink_s;
  assign bus.hour_on   = (state_q != SET_HOUR) | blink_s;
  assign bus.en1hz     = tick_s;
endmodule

// File: tb/tb_clock_hms_cfg.sv
// Self-checking bench for clock_hms_cfg at CLK_HZ=8, BLINK_HZ=2: directed
// table, hand-written corner sequences and random pulses against a time model.
module tb_clock_hms_cfg;
  localparam int CLK = 8;
  localparam int BLK = 4;

  logic clk;
  logic n_rst;
  clock_hms_cfg_if bus ();

  clock_hms_cfg #(.CLK_HZ(CLK), .BLINK_HZ(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: state 0=run,1=sec,2=min,3=hour; time as seconds of day
  int m_state;
  int m_t;
  int m_run;
  int m_set;
  logic [24:0] smp;

  typedef struct {
    bit m;
    bit s;
    bit a;
    bit h12;
    bit chk;
    int hour;
    bit pm;
    int mn;
    int sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit m, bit s, bit a, bit h12, bit chk,
                              int hour, bit pm, int mn, int sc);
    vec_t v;
    v.m = m; v.s = s; v.a = a; v.h12 = h12; v.chk = chk;
    v.hour = hour; v.pm = pm; v.mn = mn; v.sc = sc;
    return v;
  endfunction

  function automatic logic [24:0] dut_out();
    return {bus.sec_ones, bus.sec_tens, bus.min_ones, bus.min_tens,
            bus.hour_ones, bus.hour_tens, bus.pm,
            bus.sec_on, bus.min_on, bus.hour_on, bus.en1hz};
  endfunction

  function automatic int hms();
    return int'({2'b00, bus.hour_tens, bus.hour_ones, 1'b0, bus.min_tens,
                 bus.min_ones, 1'b0, bus.sec_tens, bus.sec_ones});
  endfunction

  function automatic logic [24:0] model_out();
    int s, mi, h, dh;
    logic tk, bl, son, mon, hon, pm_e;
    s  = m_t % 60;
    mi = (m_t / 60) % 60;
    h  = m_t / 3600;
    if (bus.h12) dh = (h % 12 == 0) ? 12 : h % 12;
    else dh = h;
    pm_e = (h >= 12);
    tk   = (m_state == 0) && (m_run % CLK == CLK - 1);
    bl   = (m_set % BLK) < (BLK / 2);
    son  = (m_state == 1) ? bl : 1'b1;
    mon  = (m_state == 2) ? bl : 1'b1;
    hon  = (m_state == 3) ? bl : 1'b1;
    return {4'(s % 10), 3'(s / 10), 4'(mi % 10), 3'(mi / 10),
            4'(dh % 10), 2'(dh / 10), pm_e, son, mon, hon, tk};
  endfunction

  task automatic model_reset();
    m_state = 0; m_t = 0; m_run = 0; m_set = 0;
  endtask

  task automatic model_step(input bit m, input bit s, input bit a);
    int sec, mi, h;
    sec = m_t % 60;
    mi  = (m_t / 60) % 60;
    h   = m_t / 3600;
    if (m_state == 0) begin
      if (m_run % CLK == CLK - 1) m_t = (m_t + 1) % 86400;
      m_run++;
      if (m) begin m_state = 1; m_set = 0; end
    end else if (m) begin
      m_state = 0; m_run = 0;
    end else if (s) begin
      m_state = (m_state == 3) ? 1 : m_state + 1;
      m_set = 0;
    end else begin
      if (a) begin
        case (m_state)
          1: m_t = m_t - sec + (sec + 1) % 60;
          2: m_t = m_t + (((mi + 1) % 60) - mi) * 60;
          default: m_t = m_t + (((h + 1) % 24) - h) * 3600;
        endcase
      end
      m_set++;
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive pulses, compare against the model, advance both
  task automatic tick(input bit m, input bit s, input bit a);
    bus.mode = m; bus.select = s; bus.adjust = a;
    #1;
    smp = dut_out();
    check_vec("cycle", smp, model_out());
    @(posedge clk);
    model_step(m, s, a);
    @(negedge clk);
    bus.mode = 1'b0; bus.select = 1'b0; bus.adjust = 1'b0;
  endtask

  task automatic repeat_tick(input int n, input bit m, input bit s, input bit a);
    for (int i = 0; i < n; i++) tick(m, s, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_vec("async_reset", dut_out(), model_out());
    check_val("reset_hms", hms(), 0);
    check_val("reset_on", int'({bus.sec_on, bus.min_on, bus.hour_on, bus.en1hz}), 'he);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    int ticks_seen;
    bit pat[8];
    checks = 0; failures = 0;
    n_rst = 1'b0;
    bus.mode = 1'b0; bus.select = 1'b0; bus.adjust = 1'b0; bus.h12 = 1'b0;
    model_reset();

    tbl.push_back(mk(1, 0, 0, 0, 1, 'h00, 0, 'h00, 'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 14; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 'h15, 1, 'h00, 'h00));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h03, 1, 'h00, 'h00));
    tbl.push_back(mk(0, 1, 1, 0, 1, 'h15, 1, 'h00, 'h00));
    tbl.push_back(mk(0, 0, 1, 0, 1, 'h15, 1, 'h00, 'h01));
    tbl.push_back(mk(1, 0, 1, 0, 1, 'h15, 1, 'h00, 'h01));
    tbl.push_back(mk(0, 0, 1, 0, 1, 'h15, 1, 'h00, 'h01));

    #3;
    check_vec("reset24", dut_out(), {4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 2'd0, 1'b0, 4'b1110});
    bus.h12 = 1'b1;
    #1;
    check_vec("reset12", dut_out(), {4'd0, 3'd0, 4'd0, 3'd0, 4'd2, 2'd1, 1'b0, 4'b1110});
    bus.h12 = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;

    // Free run for one minute
    ticks_seen = 0;
    for (int i = 0; i < 8 * 60; i++) begin
      tick(0, 0, 0);
      if (smp[0]) ticks_seen++;
    end
    check_val("en1hz_count", ticks_seen, 60);
    check_val("t480", hms(), 'h000100);

    // Directed table
    do_reset();
    foreach (tbl[i]) begin
      bus.h12 = tbl[i].h12;
      tick(tbl[i].m, tbl[i].s, tbl[i].a);
      if (tbl[i].chk) begin
        check_val("tbl_hour", int'({bus.hour_tens, bus.hour_ones}), tbl[i].hour);
        check_val("tbl_pm", int'(bus.pm), int'(tbl[i].pm));
        check_val("tbl_min", int'({bus.min_tens, bus.min_ones}), tbl[i].mn);
        check_val("tbl_sec", int'({bus.sec_tens, bus.sec_ones}), tbl[i].sc);
      end
    end
    bus.h12 = 1'b0;

    // Preload 23:59:58 and roll over midnight
    do_reset();
    tick(1, 0, 0);
    repeat_tick(2, 0, 1, 0);
    repeat_tick(23, 0, 0, 1);
    tick(0, 1, 0);
    repeat_tick(58, 0, 0, 1);
    tick(0, 1, 0);
    repeat_tick(59, 0, 0, 1);
    tick(1, 0, 0);
    check_val("preload", hms(), 'h235958);
    repeat_tick(8, 0, 0, 0);
    check_val("roll_59", hms(), 'h235959);
    check_val("roll_pm1", int'(bus.pm), 1);
    repeat_tick(8, 0, 0, 0);
    check_val("roll_00", hms(), 'h000000);
    check_val("roll_pm0", int'(bus.pm), 0);

    // Blink pattern in SET_MIN
    do_reset();
    tick(1, 0, 0);
    tick(0, 1, 0);
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      check_val("blink_min_on", int'(smp[2]), int'(pat[i]));
      check_val("blink_others", int'({smp[3], smp[1]}), 3);
    end
    check_val("frozen", hms(), 'h000000);

    // Async reset while setting 12:34:56
    do_reset();
    tick(1, 0, 0);
    repeat_tick(2, 0, 1, 0);
    repeat_tick(12, 0, 0, 1);
    tick(0, 1, 0);
    repeat_tick(56, 0, 0, 1);
    tick(0, 1, 0);
    repeat_tick(34, 0, 0, 1);
    repeat_tick(3, 0, 0, 0);
    check_val("set_123456", hms(), 'h123456);
    do_reset();
    repeat_tick(8, 0, 0, 0);
    check_val("after_reset_run", hms(), 'h000001);

    // Random pulses against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) bus.h12 = ~bus.h12;
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
